// File: rtl/regfile_pkg.sv
// Shared register-file writeback types and constants.
// Used by the writeback arbiter and its optional forwarding mux.
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LSU
    } wb_src_t;

endpackage

// File: rtl/wb_fwd_mux.sv
// Single read-port forwarding: returns the in-flight write data on an address match.
// Latency: combinational. Backpressure: none.
module wb_fwd_mux
    import regfile_pkg::*;
#(
    parameter int XLEN = regfile_pkg::XLEN
) (
    input  logic                  wr_en_i,
    input  logic [REG_ADDR_W-1:0] wr_addr_i,
    input  logic [XLEN-1:0]       wr_data_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic [XLEN-1:0]       rd_data_i,
    output logic [XLEN-1:0]       fwd_data_o
);

    // x0 always reads as the regfile's own value, never a forwarded one.
    assign fwd_data_o = (wr_en_i && (wr_addr_i == rd_addr_i) && (rd_addr_i != REG_ZERO))
                        ? wr_data_i : rd_data_i;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port arbiter: LSU priority, ALU forced through after MAX_WAIT denials; x0 writes dropped.
// Latency: handshake at edge N -> rf_we high N..N+1. Backpressure: loser's ready held low. WB_FWD_EN adds read forwarding.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int XLEN     = regfile_pkg::XLEN,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic [XLEN-1:0]       rf_rd_data
`ifdef WB_FWD_EN
    ,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [XLEN-1:0]       rf_rs1_data,
    input  logic [XLEN-1:0]       rf_rs2_data,
    output logic [XLEN-1:0]       fwd_rs1_data,
    output logic [XLEN-1:0]       fwd_rs2_data
`endif
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    wb_src_t               grant;
    logic                  arb_en_q;
    logic [3:0]            starve_q, starve_d;
    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_rd_q, rf_rd_d;
    logic [XLEN-1:0]       rf_data_q, rf_data_d;

    // arb_en_q keeps both readies low until the first edge after reset releases.
    always_comb begin
        grant = WB_NONE;
        if (arb_en_q) begin
            if (alu_valid && (!lsu_valid || (starve_q == MAX_WAIT_C))) begin
                grant = WB_ALU;
            end else if (lsu_valid) begin
                grant = WB_LSU;
            end
        end
    end

    assign alu_ready = (grant == WB_ALU);
    assign lsu_ready = (grant == WB_LSU);

    always_comb begin
        starve_d  = starve_q;
        rf_we_d   = 1'b0;
        rf_rd_d   = rf_rd_q;
        rf_data_d = rf_data_q;
        if (arb_en_q) begin
            if (!alu_valid || (grant == WB_ALU)) begin
                starve_d = '0;
            end else if (starve_q != MAX_WAIT_C) begin
                starve_d = starve_q + 4'd1;
            end
        end
        case (grant)
            WB_ALU: if (alu_rd != REG_ZERO) begin
                rf_we_d   = 1'b1;
                rf_rd_d   = alu_rd;
                rf_data_d = alu_data;
            end
            WB_LSU: if (lsu_rd != REG_ZERO) begin
                rf_we_d   = 1'b1;
                rf_rd_d   = lsu_rd;
                rf_data_d = lsu_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arb_en_q  <= 1'b0;
            starve_q  <= '0;
            rf_we_q   <= 1'b0;
            rf_rd_q   <= '0;
            rf_data_q <= '0;
        end else begin
            arb_en_q  <= 1'b1;
            starve_q  <= starve_d;
            rf_we_q   <= rf_we_d;
            rf_rd_q   <= rf_rd_d;
            rf_data_q <= rf_data_d;
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_rd      = rf_rd_q;
    assign rf_rd_data = rf_data_q;

`ifdef WB_FWD_EN
    wb_fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .wr_en_i    (rf_we_q),
        .wr_addr_i  (rf_rd_q),
        .wr_data_i  (rf_data_q),
        .rd_addr_i  (rs1),
        .rd_data_i  (rf_rs1_data),
        .fwd_data_o (fwd_rs1_data)
    );

    wb_fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .wr_en_i    (rf_we_q),
        .wr_addr_i  (rf_rd_q),
        .wr_data_i  (rf_data_q),
        .rd_addr_i  (rs2),
        .rd_data_i  (rf_rs2_data),
        .fwd_data_o (fwd_rs2_data)
    );
`endif

endmodule
